mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one burst memory port between two cache controllers: m0 (I-cache) and m1 (D-cache).
// - Sits between the two cache memory-side interfaces and the external memory/bus port.
// - Grants one requester per burst and holds the grant until every beat of that burst completes.
// - Routes command/write data to memory and read beats back to the granted requester only.
// PARAMETERS
// - ADDR_WIDTH   32  byte address width
// - DATA_WIDTH   32  memory beat width
// - BURST_WIDTH  2   width of burst_len; the burst is burst_len+1 beats
// PORTS
// - clock            in   1            single clock; all state changes on rising edge
// - reset            in   1            asynchronous, active-high reset
// - mN_addr          in   ADDR_WIDTH   requester N address (N=0,1; same set of ports per requester)
// - mN_burst_len     in   BURST_WIDTH  requester N burst length minus one
// - mN_rd / mN_wr    in   1            requester N read / write request, held until accepted
// - mN_wr_data       in   DATA_WIDTH   requester N write beat
// - mN_waitrequest   out  1            stall to requester N
// - mN_rd_valid      out  1            read beat valid to requester N
// - mN_rd_data       out  DATA_WIDTH   read beat, = mem_rd_data (broadcast)
// - mem_addr / mem_burst_len / mem_wr_data   out   selected requester's values
// - mem_rd / mem_wr  out  1            memory command
// - mem_waitrequest  in   1            memory stall
// - mem_rd_valid     in   1            memory read beat valid
// - mem_rd_data      in   DATA_WIDTH   memory read beat
// - grant            out  2            one-hot registered grant: 01=m0, 10=m1, 00=idle
// BEHAVIOUR
// - Reset values:
//   - state=IDLE, grant=00, beat counter=0, rr_last=1.
//   - mem_rd=mem_wr=0, mem_addr=0, mN_rd_valid=0.
// - IDLE:
//   - mem_rd=mem_wr=0; mN_waitrequest=mN_rd|mN_wr.
//   - On any request, pick a winner and register grant; cnt<=winner burst_len.
//   - Next state: RD_CMD if winner mN_rd, else WR_DATA (rd wins if both are set).
//   - Arbitration costs one cycle: command reaches memory the cycle after the request.
// - Round-robin: on a tie, grant the requester not equal to rr_last.
//   - rr_last updates when a burst ends; the first tie after reset goes to m0.
// - Granted requester's addr/burst_len/wr_data pass combinationally to the mem_* outputs.
//   - Non-granted requester sees mN_waitrequest=mN_rd|mN_wr and mN_rd_valid=0.
// - RD_CMD:
//   - mem_rd=g_rd; g_waitrequest=mem_waitrequest; mem_burst_len=latched cnt.
//   - mem_rd&~mem_waitrequest -> RD_DATA.
//   - g_rd dropped before acceptance -> IDLE, no rr update.
// - RD_DATA:
//   - mem_rd=0; g_rd_valid=mem_rd_valid; g_waitrequest=1.
//   - Each valid beat decrements cnt; a valid beat with cnt==0 -> IDLE.
// - mem_rd_valid outside RD_DATA is ignored and never forwarded.
// - WR_DATA:
//   - mem_wr=g_wr; g_waitrequest=mem_waitrequest.
//   - Each accepted beat (mem_wr&~mem_waitrequest) decrements cnt; accepted beat with cnt==0 -> IDLE.
// - Width rules: cnt is BURST_WIDTH bits; max burst is 2^BURST_WIDTH beats; cnt never wraps below 0.
// - Back-to-back bursts: after the last beat the arbiter is IDLE for one cycle, then grants again.
// - Reset mid-burst: asynchronously returns to IDLE with grant=00 and mem_rd/mem_wr=0.
//   - The burst is dropped; memory-side cleanup is the system's job.
// CONFIGURATION
// - MEM_ARB_FIXED_PRIO_EN defined: m1 always wins ties; rr_last unused.
// - MEM_ARB_FIXED_PRIO_EN undefined: round-robin as above.
// TESTING
// - m0 read len=3, waitreq 2 cycles, beats 0x11,0x22,0x33,0x44 -> m0_rd_valid x4 in order, m1_rd_valid 0, grant 00 next cycle.
// - m0,m1 read together from reset, twice each -> grants m0,m1,m0,m1; one idle cycle between bursts.
// - m1 write len=3, mem_waitrequest alternating -> exactly 4 accepted beats in order; m0 read held stalled, mem_addr = m1_addr.
// - reset during RD_DATA beat 2 -> mem_rd/mem_wr 0, grant 00 immediately; first post-reset tie goes to m0.
// - m0 read len=0, one beat 0xDEADBEEF -> one m0_rd_valid, IDLE next cycle; stray mem_rd_valid in IDLE not forwarded.
// - MEM_ARB_FIXED_PRIO_EN, both reading continuously -> m1 granted every burst; m0 waits.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst memory port between two cache controllers,
// m0 (I-cache) and m1 (D-cache). One requester is granted per burst, and the
// grant is held until the last beat of that burst completes.
// Ties are resolved round-robin by default. Defining MEM_ARB_FIXED_PRIO_EN
// switches tie resolution to a fixed priority where m1 always wins.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WIDTH = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   // requester 0 (I-cache)
   input  logic [ADDR_WIDTH-1:0]  m0_addr,
   input  logic [BURST_WIDTH-1:0] m0_burst_len,
   input  logic                   m0_rd,
   input  logic                   m0_wr,
   input  logic [DATA_WIDTH-1:0]  m0_wr_data,
   output logic                   m0_waitrequest,
   output logic                   m0_rd_valid,
   output logic [DATA_WIDTH-1:0]  m0_rd_data,
   // requester 1 (D-cache)
   input  logic [ADDR_WIDTH-1:0]  m1_addr,
   input  logic [BURST_WIDTH-1:0] m1_burst_len,
   input  logic                   m1_rd,
   input  logic                   m1_wr,
   input  logic [DATA_WIDTH-1:0]  m1_wr_data,
   output logic                   m1_waitrequest,
   output logic                   m1_rd_valid,
   output logic [DATA_WIDTH-1:0]  m1_rd_data,
   // memory port
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic [BURST_WIDTH-1:0] mem_burst_len,
   output logic [DATA_WIDTH-1:0]  mem_wr_data,
   output logic                   mem_rd,
   output logic                   mem_wr,
   input  logic                   mem_waitrequest,
   input  logic                   mem_rd_valid,
   input  logic [DATA_WIDTH-1:0]  mem_rd_data,
   output logic [1:0]             grant
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_CMD  = 2'd1,
      RD_DATA = 2'd2,
      WR_DATA = 2'd3
   } state_t;

   state_t                 state;
   logic [BURST_WIDTH-1:0] cnt;

   logic                   req0;
   logic                   req1;
   logic                   tie_to_m1;
   logic                   win_m1;
   logic                   win_rd;
   logic [BURST_WIDTH-1:0] win_len;
   logic                   g_rd;
   logic                   g_wr;
   logic                   g_waitreq;
   logic                   g_rd_valid;

   assign req0 = m0_rd | m0_wr;
   assign req1 = m1_rd | m1_wr;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign tie_to_m1 = 1'b1;
`else
   // index of the requester that finished the most recent burst (0=m0, 1=m1)
   logic rr_last;
   assign tie_to_m1 = ~rr_last;
`endif

   // winner selection used only while IDLE; a lone requester always wins
   assign win_m1  = req1 & (~req0 | tie_to_m1);
   assign win_rd  = win_m1 ? m1_rd : m0_rd;
   assign win_len = win_m1 ? m1_burst_len : m0_burst_len;

   // command bits of whichever requester currently holds the grant
   assign g_rd = (grant[1] & m1_rd) | (grant[0] & m0_rd);
   assign g_wr = (grant[1] & m1_wr) | (grant[0] & m0_wr);

   // burst sequencer: grant, beat counter and round-robin history
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         cnt   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         rr_last <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  grant <= win_m1 ? 2'b10 : 2'b01;
                  cnt   <= win_len;
                  state <= win_rd ? RD_CMD : WR_DATA;
               end
            end
            RD_CMD: begin
               // requester withdrew before the memory took the command
               if (!g_rd) begin
                  state <= IDLE;
                  grant <= '0;
               end else if (!mem_waitrequest) begin
                  state <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (mem_rd_valid) begin
                  if (cnt == '0) begin
                     state <= IDLE;
                     grant <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                     rr_last <= grant[1];
`endif
                  end else begin
                     cnt <= cnt - BURST_WIDTH'(1);
                  end
               end
            end
            WR_DATA: begin
               if (g_wr && !mem_waitrequest) begin
                  if (cnt == '0) begin
                     state <= IDLE;
                     grant <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                     rr_last <= grant[1];
`endif
                  end else begin
                     cnt <= cnt - BURST_WIDTH'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

   // memory command and granted requester handshake, decoded from state
   always_comb begin
      mem_rd         = 1'b0;
      mem_wr         = 1'b0;
      g_waitreq      = 1'b1;
      g_rd_valid     = 1'b0;
      m0_waitrequest = req0;
      m1_waitrequest = req1;
      m0_rd_valid    = 1'b0;
      m1_rd_valid    = 1'b0;
      case (state)
         RD_CMD: begin
            mem_rd    = g_rd;
            g_waitreq = mem_waitrequest;
         end
         RD_DATA: begin
            g_rd_valid = mem_rd_valid;
         end
         WR_DATA: begin
            mem_wr    = g_wr;
            g_waitreq = mem_waitrequest;
         end
         default: ;
      endcase
      if (grant[0]) begin
         m0_waitrequest = g_waitreq;
         m0_rd_valid    = g_rd_valid;
      end
      if (grant[1]) begin
         m1_waitrequest = g_waitreq;
         m1_rd_valid    = g_rd_valid;
      end
   end

   // address, length and write data follow the grant; zero when idle
   always_comb begin
      mem_addr      = '0;
      mem_burst_len = '0;
      mem_wr_data   = '0;
      if (grant[1]) begin
         mem_addr      = m1_addr;
         mem_burst_len = m1_burst_len;
         mem_wr_data   = m1_wr_data;
      end else if (grant[0]) begin
         mem_addr      = m0_addr;
         mem_burst_len = m0_burst_len;
         mem_wr_data   = m0_wr_data;
      end
      // the read command carries the length captured at grant time
      if (state == RD_CMD) begin
         mem_burst_len = cnt;
      end
   end

   assign m0_rd_data = mem_rd_data;
   assign m1_rd_data = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. Honours
// MEM_ARB_FIXED_PRIO_EN for the expected tie-break results.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [BW-1:0] m0_burst_len = '0, m1_burst_len = '0;
   logic          m0_rd = 1'b0, m0_wr = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0;
   logic [DW-1:0] m0_wr_data = '0, m1_wr_data = '0;
   logic          m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid;
   logic [DW-1:0] m0_rd_data, m1_rd_data;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_burst_len;
   logic [DW-1:0] mem_wr_data;
   logic          mem_rd, mem_wr;
   logic          mem_waitrequest = 1'b0, mem_rd_valid = 1'b0;
   logic [DW-1:0] mem_rd_data = '0;
   logic [1:0]    grant;

   int n_cmp = 0;
   int n_err = 0;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
      .clock(clock), .reset(reset),
      .m0_addr(m0_addr), .m0_burst_len(m0_burst_len), .m0_rd(m0_rd), .m0_wr(m0_wr),
      .m0_wr_data(m0_wr_data), .m0_waitrequest(m0_waitrequest),
      .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
      .m1_addr(m1_addr), .m1_burst_len(m1_burst_len), .m1_rd(m1_rd), .m1_wr(m1_wr),
      .m1_wr_data(m1_wr_data), .m1_waitrequest(m1_waitrequest),
      .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
      .mem_addr(mem_addr), .mem_burst_len(mem_burst_len), .mem_wr_data(mem_wr_data),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_waitrequest(mem_waitrequest),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .grant(grant)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   logic [DW-1:0] rbeat [4];
   logic [DW-1:0] wbeat [4];
   logic [1:0]    exp_g2 [4];
   logic [1:0]    exp_tie;
   int            acc;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rbeat[0] = 32'h11; rbeat[1] = 32'h22; rbeat[2] = 32'h33; rbeat[3] = 32'h44;
      wbeat[0] = 32'hA0A0_0001; wbeat[1] = 32'hA0A0_0002;
      wbeat[2] = 32'hA0A0_0003; wbeat[3] = 32'hA0A0_0004;
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_g2[0] = 2'b10; exp_g2[1] = 2'b10; exp_g2[2] = 2'b10; exp_g2[3] = 2'b10;
      exp_tie   = 2'b10;
`else
      exp_g2[0] = 2'b01; exp_g2[1] = 2'b10; exp_g2[2] = 2'b01; exp_g2[3] = 2'b10;
      exp_tie   = 2'b01;
`endif

      // reset state
      do_reset();
      #1;
      check("rst_grant", grant, 2'b00);
      check("rst_mem_rd", mem_rd, 1'b0);
      check("rst_mem_wr", mem_wr, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_m0_rd_valid", m0_rd_valid, 1'b0);

      // m0 read len=3, memory stalls the command for two cycles
      m0_addr = 32'h0000_0100; m0_burst_len = 2'd3; m0_rd = 1'b1;
      mem_waitrequest = 1'b1;
      #1;
      check("s1_idle_wait", m0_waitrequest, 1'b1);
      check("s1_idle_mem_rd", mem_rd, 1'b0);
      step();
      check("s1_grant", grant, 2'b01);
      check("s1_mem_rd", mem_rd, 1'b1);
      check("s1_mem_addr", mem_addr, 32'h100);
      check("s1_mem_len", mem_burst_len, 2'd3);
      check("s1_stall", m0_waitrequest, 1'b1);
      step();
      mem_waitrequest = 1'b0;
      #1;
      check("s1_accept", m0_waitrequest, 1'b0);
      step();
      m0_rd = 1'b0;
      #1;
      check("s1_data_mem_rd", mem_rd, 1'b0);
      check("s1_data_wait", m0_waitrequest, 1'b1);
      for (int i = 0; i < 4; i++) begin
         mem_rd_valid = 1'b1; mem_rd_data = rbeat[i];
         #1;
         check("s1_m0_valid", m0_rd_valid, 1'b1);
         check("s1_m0_data", m0_rd_data, rbeat[i]);
         check("s1_m1_valid", m1_rd_valid, 1'b0);
         step();
      end
      mem_rd_valid = 1'b0;
      #1;
      check("s1_end_grant", grant, 2'b00);

      // both read together from reset, two bursts each
      do_reset();
      m0_addr = 32'h1000; m1_addr = 32'h2000;
      m0_burst_len = 2'd0; m1_burst_len = 2'd0;
      m0_rd = 1'b1; m1_rd = 1'b1; mem_waitrequest = 1'b0;
      for (int b = 0; b < 4; b++) begin
         #1;
         check("s2_idle_grant", grant, 2'b00);
         check("s2_idle_mem_rd", mem_rd, 1'b0);
         step();
         check("s2_grant", grant, exp_g2[b]);
         check("s2_mem_rd", mem_rd, 1'b1);
         check("s2_mem_addr", mem_addr, exp_g2[b][1] ? 32'h2000 : 32'h1000);
         step();
         if (b == 3) begin
            m0_rd = 1'b0; m1_rd = 1'b0;
         end
         mem_rd_valid = 1'b1; mem_rd_data = b;
         #1;
         check("s2_m0_valid", m0_rd_valid, exp_g2[b][0]);
         check("s2_m1_valid", m1_rd_valid, exp_g2[b][1]);
         step();
         mem_rd_valid = 1'b0;
      end

      // m1 write len=3 with alternating waitrequest, m0 read stalled meanwhile
      m1_addr = 32'h0000_0200; m1_burst_len = 2'd3; m1_wr = 1'b1; m1_wr_data = wbeat[0];
      m0_addr = 32'h0000_0300; m0_burst_len = 2'd3;
      #1;
      step();
      m0_rd = 1'b1;
      acc = 0;
      for (int k = 0; k < 20 && acc < 4; k++) begin
         mem_waitrequest = (k % 2 == 0);
         m1_wr_data = wbeat[acc];
         #1;
         check("s3_mem_wr", mem_wr, 1'b1);
         check("s3_grant", grant, 2'b10);
         check("s3_mem_addr", mem_addr, 32'h200);
         check("s3_m0_stall", m0_waitrequest, 1'b1);
         check("s3_m1_wait", m1_waitrequest, mem_waitrequest);
         if (mem_wr && !mem_waitrequest) begin
            check("s3_wr_data", mem_wr_data, wbeat[acc]);
            acc++;
         end
         step();
         if (acc == 4) m1_wr = 1'b0;
      end
      check("s3_beats", acc, 4);
      #1;
      check("s3_end_grant", grant, 2'b00);
      check("s3_end_mem_wr", mem_wr, 1'b0);
      check("s3_m0_still_wait", m0_waitrequest, 1'b1);
      step();
      check("s3_m0_grant", grant, 2'b01);
      check("s3_m0_addr", mem_addr, 32'h300);

      // reset during the second read beat
      mem_waitrequest = 1'b0;
      step();
      m0_rd = 1'b0;
      mem_rd_valid = 1'b1; mem_rd_data = 32'hA1;
      #1;
      check("s4_beat1", m0_rd_valid, 1'b1);
      step();
      mem_rd_valid = 1'b1; mem_rd_data = 32'hA2;
      #1;
      reset = 1'b1;
      #1;
      check("s4_rst_grant", grant, 2'b00);
      check("s4_rst_mem_rd", mem_rd, 1'b0);
      check("s4_rst_mem_wr", mem_wr, 1'b0);
      check("s4_rst_valid", m0_rd_valid, 1'b0);
      mem_rd_valid = 1'b0;
      step();
      reset = 1'b0;
      m0_burst_len = 2'd0; m1_burst_len = 2'd0;
      m0_rd = 1'b1; m1_rd = 1'b1;
      #1;
      step();
      check("s4_tie_grant", grant, exp_tie);
      step();
      m0_rd = 1'b0; m1_rd = 1'b0;
      mem_rd_valid = 1'b1;
      step();
      mem_rd_valid = 1'b0;

      // single-beat read; stray valid while idle is not forwarded
      mem_rd_valid = 1'b1; mem_rd_data = 32'h5555_AAAA;
      #1;
      check("s5_stray_m0", m0_rd_valid, 1'b0);
      check("s5_stray_m1", m1_rd_valid, 1'b0);
      mem_rd_valid = 1'b0;
      m0_addr = 32'h400; m0_burst_len = 2'd0; m0_rd = 1'b1;
      step();
      check("s5_grant", grant, 2'b01);
      check("s5_mem_len", mem_burst_len, 2'd0);
      step();
      m0_rd = 1'b0;
      mem_rd_valid = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
      #1;
      check("s5_valid", m0_rd_valid, 1'b1);
      check("s5_data", m0_rd_data, 32'hDEAD_BEEF);
      step();
      mem_rd_valid = 1'b0;
      #1;
      check("s5_end_grant", grant, 2'b00);
      check("s5_end_valid", m0_rd_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
